// File: rtl/hsi_m_rx_frame_buf.sv
// Single-frame receive byte buffer: captures decoded bytes, qualifies the frame at end, serves it via ready/ack.
// Optional macro HSI_RX_BUF_CRC_STRIP_EN hides the trailing CRC16 bytes and raises the minimum frame length.
module hsi_m_rx_frame_buf #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        d,
  input  logic              d_rdy,
  input  logic              frame_end,
  input  logic [5:0]        rx_errs,
  output logic              frm_rdy,
  output logic [ADDR_W:0]   frm_len,
  output logic [7:0]        rd_dat,
  output logic              rd_vld,
  input  logic              rd_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              ovf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;
`ifdef HSI_RX_BUF_CRC_STRIP_EN
  localparam int unsigned TRIM    = 2;
  localparam int unsigned MIN_LEN = 3;
`else
  localparam int unsigned TRIM    = 0;
  localparam int unsigned MIN_LEN = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_READY} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_d_rdy_q;
  logic [LEN_W-1:0]   r_wr_ptr;
  logic [LEN_W-1:0]   r_rd_ptr;
  logic               r_full_hit;
  logic               r_frm_rdy;
  logic [LEN_W-1:0]   r_frm_len;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic               r_ovf;
  logic [7:0]         r_mem [DEPTH];

  logic               w_wr_stb;
  logic               w_full;
  logic               w_bad;
  logic               w_rd_vld;
  logic               w_last_ack;
  logic               w_wr_en;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [LEN_W-1:0]   w_wr_ptr_nxt;
  logic               w_full_set;
  logic               w_ovf_set;
  logic               w_drop;
  logic               w_accept;
  logic               w_rd_adv;
  logic               w_release;

  assign w_wr_stb   = d_rdy & ~r_d_rdy_q;
  assign w_full     = (r_wr_ptr == LEN_W'(DEPTH));
  assign w_bad      = (rx_errs != '0) || r_full_hit || (r_wr_ptr < LEN_W'(MIN_LEN));
  assign w_rd_vld   = r_frm_rdy && (r_rd_ptr < r_frm_len);
  assign w_last_ack = rd_ack && w_rd_vld && (LEN_W'(r_rd_ptr + 1'b1) == r_frm_len);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_wr_stb) w_state_nxt = frame_end ? S_CHECK : S_FILL;
      S_FILL:  if (frame_end) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_bad ? S_IDLE : S_READY;
      S_READY: if (w_last_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath control strobes; errors are judged in CHECK because the checker lags frame_end by a cycle.
  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_addr    = r_wr_ptr[ADDR_W-1:0];
    w_wr_ptr_nxt = r_wr_ptr;
    w_full_set   = 1'b0;
    w_ovf_set    = 1'b0;
    w_drop       = 1'b0;
    w_accept     = 1'b0;
    w_rd_adv     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wr_addr    = '0;
        w_wr_en      = w_wr_stb;
        w_wr_ptr_nxt = w_wr_stb ? LEN_W'(1) : '0;
      end
      S_FILL: begin
        if (w_wr_stb && w_full) begin
          w_full_set = 1'b1;
          w_ovf_set  = 1'b1;
        end else if (w_wr_stb) begin
          w_wr_en      = 1'b1;
          w_wr_ptr_nxt = LEN_W'(r_wr_ptr + 1'b1);
        end
      end
      S_CHECK: begin
        w_drop   = w_bad;
        w_accept = ~w_bad;
      end
      S_READY: begin
        w_ovf_set = w_wr_stb;
        w_rd_adv  = rd_ack && w_rd_vld;
        w_release = w_last_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_d_rdy_q  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_full_hit <= 1'b0;
      r_frm_rdy  <= 1'b0;
      r_frm_len  <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_d_rdy_q <= d_rdy;
      r_wr_ptr  <= w_wr_ptr_nxt;
      if (r_state == S_IDLE) r_full_hit <= 1'b0;
      else if (w_full_set)   r_full_hit <= 1'b1;
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= CNT_W'(r_drop_cnt + 1'b1);
      if (w_accept) begin
        r_frm_rdy <= 1'b1;
        r_frm_len <= LEN_W'(r_wr_ptr - LEN_W'(TRIM));
        r_rd_ptr  <= '0;
      end else if (w_release) begin
        r_frm_rdy <= 1'b0;
        r_frm_len <= '0;
        r_rd_ptr  <= '0;
      end else if (w_rd_adv) begin
        r_rd_ptr <= LEN_W'(r_rd_ptr + 1'b1);
      end
    end
  end

  // Storage array has no reset; reads are masked until a qualified frame is held.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= d;
  end

  assign frm_rdy  = r_frm_rdy;
  assign frm_len  = r_frm_len;
  assign rd_vld   = w_rd_vld;
  assign rd_dat   = w_rd_vld ? r_mem[r_rd_ptr[ADDR_W-1:0]] : 8'h00;
  assign busy     = (r_state != S_IDLE);
  assign drop_cnt = r_drop_cnt;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_hsi_m_rx_frame_buf.sv
// Randomized bench for hsi_m_rx_frame_buf against a frame-level reference model.
module tb_hsi_m_rx_frame_buf;

  localparam int DEPTH = 64;
`ifdef HSI_RX_BUF_CRC_STRIP_EN
  localparam int TRIM = 2;
  localparam int MIN_LEN = 3;
`else
  localparam int TRIM = 0;
  localparam int MIN_LEN = 1;
`endif

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  d = '0;
  logic        d_rdy = 1'b0;
  logic        frame_end = 1'b0;
  logic [5:0]  rx_errs = '0;
  logic        frm_rdy;
  logic [6:0]  frm_len;
  logic [7:0]  rd_dat;
  logic        rd_vld;
  logic        rd_ack = 1'b0;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;
  int exp_drop = 0;
  bit exp_ovf = 1'b0;

  hsi_m_rx_frame_buf #(.ADDR_W(6), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .d(d), .d_rdy(d_rdy), .frame_end(frame_end),
    .rx_errs(rx_errs), .frm_rdy(frm_rdy), .frm_len(frm_len), .rd_dat(rd_dat),
    .rd_vld(rd_vld), .rd_ack(rd_ack), .busy(busy), .drop_cnt(drop_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    d = b;
    d_rdy = 1'b1;
    repeat (hold) tick();
    d_rdy = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    rd_ack = 1'b0;
    d_rdy = 1'b0;
    frame_end = 1'b0;
    #1;
    check_val("rst_frm_rdy", frm_rdy, 0);
    check_val("rst_frm_len", frm_len, 0);
    check_val("rst_rd_dat", rd_dat, 0);
    check_val("rst_rd_vld", rd_vld, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_drop_cnt", drop_cnt, 0);
    check_val("rst_ovf", ovf, 0);
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    exp_drop = 0;
    exp_ovf = 1'b0;
  endtask

  // hold=0 picks a random d_rdy high time per byte; n_abort>0 resets after that many acks.
  task automatic run_frame(input bq_t q, input logic [5:0] errs, input int n_intr,
                           input bit ack_hold, input bit merge_end, input int hold, input int n_abort);
    bit full;
    bit acc;
    bit ack;
    int stored;
    int explen;
    int idx;
    int guard;
    full   = q.size() > DEPTH;
    stored = full ? DEPTH : q.size();
    acc    = (errs == 0) && !full && (stored >= MIN_LEN);
    explen = acc ? stored - TRIM : 0;

    for (int i = 0; i < q.size(); i++) begin
      if (merge_end && i == q.size() - 1) begin
        d = q[i];
        d_rdy = 1'b1;
        frame_end = 1'b1;
        rx_errs = errs;
        tick();
      end else begin
        send_byte(q[i], (hold == 0) ? int'($urandom_range(1, 3)) : hold);
      end
    end
    if (!merge_end) begin
      frame_end = 1'b1;
      rx_errs = errs;
      tick();
    end
    frame_end = 1'b0;
    d_rdy = 1'b0;
    if (full) exp_ovf = 1'b1;
    check_val("check_frm_rdy", frm_rdy, 0);
    check_val("check_busy", busy, 1);
    tick();
    rx_errs = '0;

    if (!acc) begin
      if (exp_drop < 255) exp_drop++;
      check_val("drop_frm_rdy", frm_rdy, 0);
      check_val("drop_busy", busy, 0);
      check_val("drop_cnt", drop_cnt, exp_drop);
      check_val("drop_ovf", ovf, exp_ovf);
      return;
    end

    check_val("acc_frm_rdy", frm_rdy, 1);
    check_val("acc_frm_len", frm_len, explen);
    check_val("acc_drop_cnt", drop_cnt, exp_drop);
    for (int i = 0; i < n_intr; i++) begin
      send_byte(8'($urandom), int'($urandom_range(1, 3)));
      exp_ovf = 1'b1;
    end
    if (n_intr > 0) begin
      check_val("intr_ovf", ovf, 1);
      check_val("intr_frm_len", frm_len, explen);
    end

    idx = 0;
    guard = 0;
    while (idx < explen && guard < 1000) begin
      if (n_abort > 0 && idx == n_abort) begin
        rd_ack = 1'b0;
        apply_reset();
        return;
      end
      check_val("rd_frm_rdy", frm_rdy, 1);
      check_val("rd_vld", rd_vld, 1);
      check_val("rd_dat", rd_dat, q[idx]);
      ack = ack_hold ? 1'b1 : 1'($urandom_range(0, 1));
      rd_ack = ack;
      tick();
      if (ack) idx++;
      guard++;
    end
    rd_ack = 1'b0;
    if (guard >= 1000) check_val("rd_timeout", 0, 1);
    if (ack_hold) check_val("rd_cycles", guard, explen);
    check_val("end_frm_rdy", frm_rdy, 0);
    check_val("end_rd_vld", rd_vld, 0);
    check_val("end_frm_len", frm_len, 0);
    check_val("end_busy", busy, 0);
    check_val("end_ovf", ovf, exp_ovf);
    check_val("end_drop_cnt", drop_cnt, exp_drop);
  endtask

  function automatic bq_t rand_frame(input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    bq_t q5;
    bq_t q;
    q5 = '{8'h11, 8'h22, 8'h33, 8'hA5, 8'h5A};

    apply_reset();
    run_frame(q5, 6'd0, 0, 1'b1, 1'b0, 3, 0);
    check_val("ovf_clean", ovf, 0);
    run_frame(q5, 6'b000100, 0, 1'b1, 1'b0, 3, 0);
    run_frame(rand_frame(2), 6'd0, 0, 1'b1, 1'b0, 0, 0);
    run_frame(rand_frame(70), 6'd0, 0, 1'b1, 1'b0, 1, 0);
    check_val("ovf_full", ovf, 1);
    run_frame(rand_frame(64), 6'd0, 0, 1'b0, 1'b0, 1, 0);
    run_frame(q5, 6'd0, 3, 1'b0, 1'b0, 0, 0);
    run_frame(q5, 6'd0, 0, 1'b1, 1'b0, 2, 2);
    run_frame(rand_frame(4), 6'd0, 0, 1'b1, 1'b0, 0, 0);
    run_frame(rand_frame(1), 6'd0, 0, 1'b1, 1'b1, 0, 0);
    run_frame(rand_frame(6), 6'd0, 0, 1'b0, 1'b1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int len;
      logic [5:0] e;
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 68)) : int'($urandom_range(1, 12));
      e = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      q = rand_frame(len);
      run_frame(q, e, ($urandom_range(0, 7) == 0) ? 2 : 0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 0, 0);
    end

    for (int n = 0; n < 255; n++)
      run_frame(rand_frame(int'($urandom_range(1, 3))), 6'($urandom_range(1, 63)), 0, 1'b1, 1'b0, 1, 0);
    check_val("drop_sat_pre", drop_cnt, 8'hFF);
    run_frame(rand_frame(2), 6'b100000, 0, 1'b1, 1'b0, 1, 0);
    check_val("drop_sat", drop_cnt, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
